mod_74x32_n_reg: RTL

Parametrised, clocked successor to the quad 2-input OR gate model: N independent OR channels with a selectable function mode, per-channel sticky capture and rising-edge detection, a registered output pipeline of configurable depth, and hold control. It sits in the 74xx model library as the synchronous gate-bank primitive for wide flag and condition-capture logic, in place of chaining multiple quad-OR packages.

---
 rtl/mod_74x32_n_reg_if.sv | 35 +++
 rtl/mod_74x32_n_reg.sv | 96 +++++++++
 2 files changed

// File: rtl/mod_74x32_n_reg_if.sv
// Bus interface for mod_74x32_n_reg: control, operands and results of the
// N-channel clocked OR bank.
//   en     sample/advance enable (0 freezes all state except the sticky clear)
//   clr    synchronous clear of the sticky capture register
//   mode   function select: 00 OR, 01 NOR, 10 STICKY, 11 RISE
//   a, b   operands, index 0 is channel 1
//   y      registered result after the configured pipeline depth
//   any_c  OR-reduction of y (combinational from y only)
//   valid  pipeline has held a full set of enabled samples since reset
interface mod_74x32_n_reg_if #(
  parameter int unsigned N = 4
) ();

  logic         en;
  logic         clr;
  logic [1:0]   mode;
  logic [0:N-1] a;
  logic [0:N-1] b;
  logic [0:N-1] y;
  logic         any_c;
  logic         valid;

  // Driver side (testbench or parent logic)
  modport master (
    output en, clr, mode, a, b,
    input  y, any_c, valid
  );

  // Gate-bank side
  modport slave (
    input  en, clr, mode, a, b,
    output y, any_c, valid
  );

endinterface

// File: rtl/mod_74x32_n_reg.sv
// Clocked N-channel OR gate bank with selectable function (OR, NOR, sticky
// capture, rising-edge detect), an output pipeline of STAGES registers and
// enable/hold control.
//   clk_i  clock, all state changes on the rising edge
//   rst_i  synchronous active-high reset, overrides every other control
//   bus    mod_74x32_n_reg_if.slave: en, clr, mode, a, b in; y, any_c, valid out
module mod_74x32_n_reg #(
  parameter int unsigned N      = 4,
  parameter int unsigned STAGES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mod_74x32_n_reg_if.slave      bus
);

  typedef logic [0:N-1] chan_t;

  typedef enum logic [1:0] {
    MODE_OR     = 2'b00,
    MODE_NOR    = 2'b01,
    MODE_STICKY = 2'b10,
    MODE_RISE   = 2'b11
  } mode_e;

  chan_t             o_c;
  chan_t             f_c;
  chan_t             sticky_q, sticky_d;
  chan_t             prev_q,   prev_d;
  chan_t             pipe_q [STAGES];
  chan_t             pipe_d [STAGES];
  logic [STAGES-1:0] vld_q,    vld_d;

  // Stage-0 function, sticky/previous update and pipeline advance
  always_comb begin
    o_c      = bus.a | bus.b;
    f_c      = '0;
    sticky_d = sticky_q;
    prev_d   = prev_q;
    pipe_d   = pipe_q;
    vld_d    = vld_q;

    if (bus.en) begin
      unique case (mode_e'(bus.mode))
        MODE_OR:     f_c = o_c;
        MODE_NOR:    f_c = ~o_c;
        MODE_STICKY: begin
          // A clear on the same sample discards the current O entirely
          f_c      = bus.clr ? chan_t'('0) : (sticky_q | o_c);
          sticky_d = sticky_q | o_c;
        end
        MODE_RISE:   f_c = o_c & ~prev_q;
        default:     f_c = '0;
      endcase

      // Track O in every mode so RISE is correct right after a mode switch
      prev_d = o_c;

      pipe_d[0] = f_c;
      vld_d[0]  = 1'b1;
      for (int unsigned k = 1; k < STAGES; k++) begin
        pipe_d[k] = pipe_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end

    // Clear wins over accumulation and acts even while disabled
    if (bus.clr) begin
      sticky_d = '0;
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sticky_q <= '0;
      prev_q   <= '0;
      vld_q    <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      sticky_q <= sticky_d;
      prev_q   <= prev_d;
      vld_q    <= vld_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign bus.y     = pipe_q[STAGES-1];
  assign bus.valid = vld_q[STAGES-1];
  // Reduction of the registered result only; no path from the inputs
  assign bus.any_c = |pipe_q[STAGES-1];

endmodule
